gpio_in_sync_filter: RTL and testbench

Per-pin input conditioning stage for the DP0 pad ring, downstream of the pinmux pad cells. It synchronizes the raw pad inputs from `async_in_from_pad_mscbus` into the GPIO clock domain. It applies a programmable counter-based glitch filter and produces the GPIO data-in bus `GP_DATA_IN_out_mscbus`. It also produces per-pin rise/fall event pulses and a sticky, write-1-to-clear interrupt status with a combined interrupt line.

---
 rtl/gpio_in_sync_filter.sv | 146 ++++++++++++++
 tb/tb_gpio_in_sync_filter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_in_sync_filter.sv
// gpio_in_sync_filter: per-pin input conditioning for the pad ring.
// Raw pad inputs pass through a two-flop synchronizer and then a counter-based
// glitch filter paced by a selectable sample tick. The block also produces
// registered rise/fall event pulses, a sticky write-1-to-clear status and a
// combined interrupt line. Every pin is identical and independent.
module gpio_in_sync_filter #(
  parameter int unsigned NUM_PINS   = 32,
  parameter int unsigned FILT_CNT_W = 3,
  // Legal range 1..2**FILT_CNT_W; the counter only ever reaches FILT_LEN-1.
  parameter int unsigned FILT_LEN   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_PINS-1:0]   async_in_from_pad_mscbus,
  input  logic [NUM_PINS-1:0]   inena_out_mscbus,
  input  logic [NUM_PINS-1:0]   glitch_filter_bypass_out_mscbus,
  input  logic [2*NUM_PINS-1:0] glitch_filter_debounce_clk_sel_out_mscbus,
  input  logic [3:0]            i_sample_tick,
  input  logic [NUM_PINS-1:0]   i_irq_en_rise,
  input  logic [NUM_PINS-1:0]   i_irq_en_fall,
  input  logic [NUM_PINS-1:0]   i_irq_clr,
  output logic [NUM_PINS-1:0]   GP_DATA_IN_out_mscbus,
  output logic [NUM_PINS-1:0]   o_rise_evt,
  output logic [NUM_PINS-1:0]   o_fall_evt,
  output logic [NUM_PINS-1:0]   o_irq_status,
  output logic                  o_irq
);

  // Count value at which the next mismatching tick accepts the new level.
  localparam logic [FILT_CNT_W-1:0] CntLast = FILT_CNT_W'(FILT_LEN - 1);

  logic [NUM_PINS-1:0]   sync1_q;
  logic [NUM_PINS-1:0]   sync2_q;
  logic [NUM_PINS-1:0]   filt_q;
  logic [NUM_PINS-1:0]   filt_d;
  logic [FILT_CNT_W-1:0] cnt_q [NUM_PINS];
  logic [FILT_CNT_W-1:0] cnt_d [NUM_PINS];
  logic [NUM_PINS-1:0]   tick_sel;
  // Set when filt may legitimately take the synchronized level (bypass or
  // filter acceptance); a forced clear by input-enable never sets it.
  logic [NUM_PINS-1:0]   accept;
  logic [NUM_PINS-1:0]   rise_d;
  logic [NUM_PINS-1:0]   rise_q;
  logic [NUM_PINS-1:0]   fall_d;
  logic [NUM_PINS-1:0]   fall_q;
  logic [NUM_PINS-1:0]   status_d;
  logic [NUM_PINS-1:0]   status_q;
  logic                  irq_q;

  // Two-flop synchronizer bringing the pad levels into the i_clk domain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= async_in_from_pad_mscbus;
      sync2_q <= sync1_q;
    end
  end

  // Per-pin sample tick chosen by the two select bits of that pin.
  always_comb begin
    tick_sel = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      tick_sel[i] = i_sample_tick[glitch_filter_debounce_clk_sel_out_mscbus[2*i +: 2]];
    end
  end

  // Filter next state; the first matching rule wins.
  always_comb begin
    filt_d = filt_q;
    accept = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!inena_out_mscbus[i]) begin
        filt_d[i] = 1'b0;
        cnt_d[i]  = '0;
      end else if (glitch_filter_bypass_out_mscbus[i]) begin
        filt_d[i] = sync2_q[i];
        cnt_d[i]  = '0;
        accept[i] = 1'b1;
      end else if (tick_sel[i]) begin
        if (sync2_q[i] == filt_q[i]) begin
          // Level agrees again: any partial count is thrown away.
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CntLast) begin
          filt_d[i] = sync2_q[i];
          cnt_d[i]  = '0;
          accept[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Event pulses line up with the cycle in which the new filt value appears.
  always_comb begin
    rise_d = accept & ~filt_q & filt_d;
    fall_d = accept & filt_q & ~filt_d;
  end

  // Sticky status: a new event beats a simultaneous clear.
  always_comb begin
    status_d = (status_q & ~i_irq_clr)
             | (rise_q & i_irq_en_rise)
             | (fall_q & i_irq_en_fall);
  end

  // Filter level and per-pin counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      filt_q <= '0;
      for (int i = 0; i < NUM_PINS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      filt_q <= filt_d;
      for (int i = 0; i < NUM_PINS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Registered events, status and combined interrupt.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rise_q   <= '0;
      fall_q   <= '0;
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      status_q <= status_d;
      irq_q    <= |status_q;
    end
  end

  assign GP_DATA_IN_out_mscbus = filt_q;
  assign o_rise_evt            = rise_q;
  assign o_fall_evt            = fall_q;
  assign o_irq_status          = status_q;
  assign o_irq                 = irq_q;

endmodule

// File: tb/tb_gpio_in_sync_filter.sv
// Scoreboard bench for gpio_in_sync_filter: stimulus pushes per-cycle
// expected output values into a queue; a monitor compares them on the
// falling clock edge of the cycle they belong to.
module tb_gpio_in_sync_filter;

  localparam int NP = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP-1:0]   pad;
  logic [NP-1:0]   inena;
  logic [NP-1:0]   bypass;
  logic [2*NP-1:0] sel;
  logic [3:0]      tick;
  logic [NP-1:0]   en_rise;
  logic [NP-1:0]   en_fall;
  logic [NP-1:0]   clr;
  logic [NP-1:0]   data;
  logic [NP-1:0]   rise;
  logic [NP-1:0]   fall;
  logic [NP-1:0]   status;
  logic            irq;

  gpio_in_sync_filter #(
    .NUM_PINS   (NP),
    .FILT_CNT_W (3),
    .FILT_LEN   (4)
  ) dut (
    .i_clk                                     (clk),
    .i_rst                                     (rst),
    .async_in_from_pad_mscbus                  (pad),
    .inena_out_mscbus                          (inena),
    .glitch_filter_bypass_out_mscbus           (bypass),
    .glitch_filter_debounce_clk_sel_out_mscbus (sel),
    .i_sample_tick                             (tick),
    .i_irq_en_rise                             (en_rise),
    .i_irq_en_fall                             (en_fall),
    .i_irq_clr                                 (clr),
    .GP_DATA_IN_out_mscbus                     (data),
    .o_rise_evt                                (rise),
    .o_fall_evt                                (fall),
    .o_irq_status                              (status),
    .o_irq                                     (irq)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t  sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    done     = 1'b0;
  string sig_name [5] = '{"data_in", "rise_evt", "fall_evt", "irq_status", "irq"};

  function automatic logic [31:0] sample(input int s);
    case (s)
      0:       return data;
      1:       return rise;
      2:       return fall;
      3:       return status;
      default: return {31'b0, irq};
    endcase
  endfunction

  task automatic expect_win(input int from, input int to, input int s, input logic [31:0] v);
    exp_t e;
    for (int c = from; c <= to; c++) begin
      e.cyc = c;
      e.sig = s;
      e.val = v;
      sb.push_back(e);
    end
  endtask

  // Value v at cycle 'at', zero on every other cycle of the window.
  task automatic expect_pulse(input int from, input int to, input int at, input int s,
                              input logic [31:0] v);
    expect_win(from, at - 1, s, 32'h0);
    expect_win(at, at, s, v);
    expect_win(at + 1, to, s, 32'h0);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pops every expectation due this cycle and compares it.
  initial begin : monitor
    exp_t        keep[$];
    logic [31:0] got;
    while (!done) begin
      @(negedge clk);
      keep = {};
      foreach (sb[i]) begin
        if (sb[i].cyc == cyc) begin
          got = sample(sb[i].sig);
          n_checks++;
          if (got !== sb[i].val) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h, expected %h",
                     sig_name[sb[i].sig], cyc, got, sb[i].val);
          end
        end else if (sb[i].cyc < cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s @cycle %0d: never compared, expected %h",
                   sig_name[sb[i].sig], sb[i].cyc, sb[i].val);
        end else begin
          keep.push_back(sb[i]);
        end
      end
      sb = keep;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected done");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    rst     = 1'b1;
    pad     = '0;
    inena   = '1;
    bypass  = '1;
    sel     = '0;
    tick    = '0;
    en_rise = '0;
    en_fall = '0;
    clr     = '0;

    // Reset state, then release with bypass and input enable on.
    for (int s = 0; s < 5; s++) expect_win(1, 3, s, 32'h0);
    step(4);
    rst = 1'b0;
    for (int s = 0; s < 5; s++) expect_win(5, 6, s, 32'h0);
    step(2);

    // Bypass: pin 3 rises three edges after the pad change.
    n = cyc;
    pad[3] = 1'b1;
    expect_win(n + 1, n + 2, 0, 32'h0);
    expect_win(n + 3, n + 5, 0, 32'h8);
    expect_pulse(n + 1, n + 5, n + 3, 1, 32'h8);
    for (int s = 2; s < 5; s++) expect_win(n + 1, n + 5, s, 32'h0);
    step(5);

    // Filter on tick[0]: a 3-cycle pad pulse on pin 5 is rejected.
    n = cyc;
    bypass = '0;
    tick   = 4'b0001;
    pad[5] = 1'b1;
    expect_win(n + 1, n + 8, 0, 32'h8);
    expect_win(n + 1, n + 8, 1, 32'h0);
    expect_win(n + 1, n + 8, 2, 32'h0);
    step(3);
    pad[5] = 1'b0;
    step(5);

    // A held level is accepted after the sync delay plus four ticks.
    n = cyc;
    pad[5] = 1'b1;
    expect_win(n + 1, n + 5, 0, 32'h8);
    expect_win(n + 6, n + 8, 0, 32'h28);
    expect_pulse(n + 1, n + 8, n + 6, 1, 32'h20);
    expect_win(n + 1, n + 8, 2, 32'h0);
    step(8);

    // A 2-cycle low glitch inside a stable high produces no fall.
    n = cyc;
    pad[5] = 1'b0;
    expect_win(n + 1, n + 8, 0, 32'h28);
    expect_win(n + 1, n + 8, 1, 32'h0);
    expect_win(n + 1, n + 8, 2, 32'h0);
    step(2);
    pad[5] = 1'b1;
    step(6);

    // Pin 7 on tick[2] pulsing every 8 clocks; ticks 1 and 3 toggle freely.
    n = cyc;
    sel[15:14] = 2'b10;
    pad[7]     = 1'b1;
    expect_win(n + 1, n + 31, 0, 32'h28);
    expect_win(n + 32, n + 40, 0, 32'ha8);
    expect_pulse(n + 1, n + 40, n + 32, 1, 32'h80);
    expect_win(n + 1, n + 40, 2, 32'h0);
    for (int k = 0; k < 40; k++) begin
      tick = {k[0], (k % 8 == 7), k[0], 1'b1};
      step(1);
    end
    tick = 4'b0001;

    // Input enable drop forces pin 5 low with no fall event.
    n = cyc;
    inena[5] = 1'b0;
    expect_win(n + 1, n + 3, 0, 32'h88);
    expect_win(n + 1, n + 3, 1, 32'h0);
    expect_win(n + 1, n + 3, 2, 32'h0);
    step(3);

    // Re-enable with the pad high: rise after four ticks.
    n = cyc;
    inena[5] = 1'b1;
    expect_win(n + 1, n + 3, 0, 32'h88);
    expect_win(n + 4, n + 5, 0, 32'ha8);
    expect_pulse(n + 1, n + 5, n + 4, 1, 32'h20);
    expect_win(n + 1, n + 5, 2, 32'h0);
    step(5);

    // Interrupt: rise on bypassed pin 9 sets status, irq one cycle later.
    n = cyc;
    bypass[9]  = 1'b1;
    en_rise[9] = 1'b1;
    pad[9]     = 1'b1;
    expect_win(n + 1, n + 2, 0, 32'ha8);
    expect_win(n + 3, n + 6, 0, 32'h2a8);
    expect_pulse(n + 1, n + 6, n + 3, 1, 32'h200);
    expect_win(n + 1, n + 3, 3, 32'h0);
    expect_win(n + 4, n + 6, 3, 32'h200);
    expect_win(n + 1, n + 4, 4, 32'h0);
    expect_win(n + 5, n + 6, 4, 32'h1);
    step(6);

    // Fall with en_fall=0 leaves the set status bit alone.
    n = cyc;
    pad[9] = 1'b0;
    expect_win(n + 1, n + 2, 0, 32'h2a8);
    expect_win(n + 3, n + 5, 0, 32'ha8);
    expect_pulse(n + 1, n + 5, n + 3, 2, 32'h200);
    expect_win(n + 1, n + 5, 1, 32'h0);
    expect_win(n + 1, n + 5, 3, 32'h200);
    expect_win(n + 1, n + 5, 4, 32'h1);
    step(5);

    // Clear alone: status drops, irq follows one cycle later.
    n = cyc;
    clr[9] = 1'b1;
    expect_win(n + 1, n + 3, 3, 32'h0);
    expect_win(n + 1, n + 1, 4, 32'h1);
    expect_win(n + 2, n + 3, 4, 32'h0);
    step(1);
    clr = '0;
    step(2);

    // Clear coincident with a new rise event: the bit stays set.
    n = cyc;
    pad[9] = 1'b1;
    expect_pulse(n + 1, n + 6, n + 3, 1, 32'h200);
    expect_win(n + 1, n + 3, 3, 32'h0);
    expect_win(n + 4, n + 6, 3, 32'h200);
    expect_win(n + 1, n + 4, 4, 32'h0);
    expect_win(n + 5, n + 6, 4, 32'h1);
    step(3);
    clr[9] = 1'b1;
    step(1);
    clr = '0;
    step(2);

    // Reset mid-count on pin 11, then a full restart from filt=0.
    bypass  = '0;
    en_rise = '0;
    step(3);
    n = cyc;
    pad[11] = 1'b1;
    expect_win(n + 1, n + 3, 0, 32'h2a8);
    step(4);
    rst = 1'b1;
    for (int s = 0; s < 5; s++) expect_win(n + 4, n + 6, s, 32'h0);
    step(2);
    rst = 1'b0;
    expect_win(n + 7, n + 11, 0, 32'h0);
    expect_win(n + 12, n + 14, 0, 32'ha28);
    expect_pulse(n + 7, n + 14, n + 12, 1, 32'ha28);
    for (int s = 2; s < 5; s++) expect_win(n + 7, n + 14, s, 32'h0);
    step(8);
    done = 1'b1;
  end

endmodule
